// File: rtl/rom_loader_pkg.sv
// Shared types and helpers for the boot-ROM download loader.
package rom_loader_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_CE = 2'd1,
        WRITE   = 2'd2
    } ldr_state_t;

    localparam int PAGE_W_DEFAULT = 14;
    localparam int MAX_SLOTS      = 16;

    // Extract target page idx (each `width` bits wide) from a packed page table.
    // The table is widened to a fixed 512 bits so one helper serves any SLOTS/width.
    function automatic logic [31:0] slot_page(input logic [511:0] pages,
                                              input int           idx,
                                              input int           width);
        logic [511:0] mask;
        mask = (512'd1 << width) - 512'd1;
        return 32'((pages >> (idx * width)) & mask);
    endfunction

endpackage

// File: rtl/rom_slot_map.sv
// Combinational page/slot decoder.
// Forward mode: input page number is a download page; hit when it names a slot.
// Reverse mode: input page is an SDRAM page; hit when it is any slot's target.
module rom_slot_map
    import rom_loader_pkg::*;
#(
    parameter int                    SLOTS      = 3,
    parameter int                    IN_W       = 11,
    parameter int                    PG_W       = 9,
    parameter bit                    REVERSE    = 1'b0,
    parameter logic [SLOTS*PG_W-1:0] SLOT_PAGES = '0
) (
    input  logic [IN_W-1:0] page,
    output logic            hit,
    output logic [3:0]      index
);

    // Decode the page against the slot table
    always_comb begin
        hit   = 1'b0;
        index = '0;
        if (REVERSE) begin
            for (int i = 0; i < SLOTS; i++) begin
                if (IN_W'(slot_page(512'(SLOT_PAGES), i, PG_W)) == page) begin
                    hit   = 1'b1;
                    index = 4'(i);
                end
            end
        end else if (32'(page) < 32'(SLOTS)) begin
            hit   = 1'b1;
            index = 4'(page);
        end
    end

endmodule

// File: rtl/rom_loader.sv
// ioctl download -> SDRAM boot write port, with per-slot page remapping.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for an ioctl byte; out-of-range pages are dropped here
// WAIT_CE | byte latched, ioctl_wait high, waiting for ce to raise boot_wr
// WRITE   | boot_wr high for one ce period; next ce completes the write
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int   SLOTS    = 3,
    parameter int   ADDR_W   = 23,
    parameter int   IOCTL_AW = 25,
    parameter int   PAGE_W   = PAGE_W_DEFAULT,
    parameter logic [7:0] INDEX = 8'd0,
    parameter logic [SLOTS*(ADDR_W-PAGE_W)-1:0] SLOT_PAGES = {9'h107, 9'h100, 9'h000}
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                ce,
    input  logic                ioctl_download,
    input  logic [7:0]          ioctl_index,
    input  logic                ioctl_wr,
    input  logic [IOCTL_AW-1:0] ioctl_addr,
    input  logic [7:0]          ioctl_dout,
    output logic                ioctl_wait,
    output logic                active,
    output logic                boot_wr,
    output logic [ADDR_W-1:0]   boot_a,
    output logic [7:0]          boot_dout,
    input  logic [ADDR_W-1:0]   mem_a,
    output logic [7:0]          rom_mask,
    output logic [SLOTS-1:0]    loaded,
    output logic [15:0]         drop_cnt,
    output logic                proto_err,
    output logic                done
);

    localparam int PG_W = ADDR_W - PAGE_W;
    localparam int IN_W = IOCTL_AW - PAGE_W;

    ldr_state_t state, state_nxt;

    logic            wr_hit;
    logic [3:0]      wr_idx;
    logic [PG_W-1:0] wr_target;
    logic            mem_hit;
    logic [3:0]      mem_idx_unused;
    logic [PAGE_W-1:0] mem_ofs_unused;

    logic            accept, drop, fire, finish, proto;
    logic [3:0]      slot_q;
    logic            active_q, act_rise, act_fall;
    logic            done_pend, done_fire;
    logic [15:0]     drop_base, drop_inc;
    logic [SLOTS-1:0] loaded_set;

    assign active = ioctl_download & (ioctl_index == INDEX);

    rom_slot_map #(
        .SLOTS      (SLOTS),
        .IN_W       (IN_W),
        .PG_W       (PG_W),
        .REVERSE    (1'b0),
        .SLOT_PAGES (SLOT_PAGES)
    ) u_wr_map (
        .page  (ioctl_addr[IOCTL_AW-1:PAGE_W]),
        .hit   (wr_hit),
        .index (wr_idx)
    );

    rom_slot_map #(
        .SLOTS      (SLOTS),
        .IN_W       (PG_W),
        .PG_W       (PG_W),
        .REVERSE    (1'b1),
        .SLOT_PAGES (SLOT_PAGES)
    ) u_mem_map (
        .page  (mem_a[ADDR_W-1:PAGE_W]),
        .hit   (mem_hit),
        .index (mem_idx_unused)
    );

    assign mem_ofs_unused = mem_a[PAGE_W-1:0];
    assign rom_mask       = mem_hit ? 8'h00 : 8'hFF;
    assign wr_target      = PG_W'(slot_page(512'(SLOT_PAGES), int'(wr_idx), PG_W));

    assign act_rise  = active & ~active_q;
    assign act_fall  = ~active & active_q;
    assign done_fire = (act_fall | done_pend) & (state == IDLE);

    // State register
    always_ff @(posedge clk_sys) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and single-cycle action strobes
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        drop      = 1'b0;
        fire      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (active && ioctl_wr) begin
                    if (wr_hit) begin
                        accept    = 1'b1;
                        state_nxt = WAIT_CE;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            WAIT_CE: begin
                if (ce) begin
                    fire      = 1'b1;
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (ce) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign proto = active & ioctl_wr & (state != IDLE);

    // Write path: latch byte and address on accept, pace boot_wr with ce
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            boot_a     <= '0;
            boot_dout  <= '0;
            boot_wr    <= 1'b0;
            ioctl_wait <= 1'b0;
            slot_q     <= '0;
        end else begin
            if (accept) begin
                boot_a     <= {wr_target, ioctl_addr[PAGE_W-1:0]};
                boot_dout  <= ioctl_dout;
                slot_q     <= wr_idx;
                ioctl_wait <= 1'b1;
            end
            if (fire) boot_wr <= 1'b1;
            if (finish) begin
                boot_wr    <= 1'b0;
                ioctl_wait <= 1'b0;
            end
        end
    end

    // A new download clears status first; events in the same cycle still count.
    assign drop_base  = act_rise ? 16'h0000 : drop_cnt;
    assign drop_inc   = (drop_base == 16'hFFFF) ? drop_base : drop_base + 16'd1;
    assign loaded_set = finish ? (SLOTS'(1) << slot_q) : '0;

    // Download status: loaded bitmap, drop counter, sticky protocol error
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            loaded    <= '0;
            drop_cnt  <= '0;
            proto_err <= 1'b0;
        end else begin
            loaded    <= (act_rise ? '0 : loaded) | loaded_set;
            drop_cnt  <= drop ? drop_inc : drop_base;
            proto_err <= (act_rise ? 1'b0 : proto_err) | proto;
        end
    end

    // Download end: pulse done once the loader is back in IDLE
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            active_q  <= 1'b0;
            done_pend <= 1'b0;
            done      <= 1'b0;
        end else begin
            active_q  <= active;
            done      <= done_fire;
            done_pend <= act_rise ? 1'b0 : ((act_fall | done_pend) & ~done_fire);
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// Randomized bench for rom_loader against a page-table reference model.
module tb_rom_loader;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b0;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        ioctl_wait;
    logic        active;
    logic        boot_wr;
    logic [22:0] boot_a;
    logic [7:0]  boot_dout;
    logic [22:0] mem_a = '0;
    logic [7:0]  rom_mask;
    logic [2:0]  loaded;
    logic [15:0] drop_cnt;
    logic        proto_err;
    logic        done;

    rom_loader dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ce             (ce),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .active         (active),
        .boot_wr        (boot_wr),
        .boot_a         (boot_a),
        .boot_dout      (boot_dout),
        .mem_a          (mem_a),
        .rom_mask       (rom_mask),
        .loaded         (loaded),
        .drop_cnt       (drop_cnt),
        .proto_err      (proto_err),
        .done           (done)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_err    = 0;

    // reference model state
    logic [8:0]  pages [3] = '{9'h000, 9'h100, 9'h107};
    logic [2:0]  m_loaded = '0;
    int          m_drop   = 0;

    // write monitor state
    int          wr_count = 0;
    logic [22:0] last_a   = '0;
    logic [7:0]  last_d   = '0;
    int          ce_in_wr = 0;
    logic        prev_wr  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_mask(input logic [22:0] a);
        for (int i = 0; i < 3; i++)
            if (pages[i] == a[22:14]) return 8'h00;
        return 8'hFF;
    endfunction

    // ce: one-cycle strobe with a random gap of 1..4 cycles
    initial begin
        forever begin
            repeat ($urandom_range(1, 4)) begin
                @(posedge clk_sys);
                #1 ce = 1'b0;
            end
            @(posedge clk_sys);
            #1 ce = 1'b1;
        end
    end

    // boot_wr pulses: capture each write, check it spans exactly one ce
    always @(negedge clk_sys) begin
        if (boot_wr && !prev_wr) begin
            wr_count++;
            last_a   = boot_a;
            last_d   = boot_dout;
            ce_in_wr = 0;
        end
        if (boot_wr && ce) ce_in_wr++;
        if (!boot_wr && prev_wr && !reset) chk("wr_ce_span", ce_in_wr, 1);
        prev_wr = boot_wr;
    end

    task automatic step(output bit c);
        @(posedge clk_sys);
        c = ce;
        #1;
    endtask

    task automatic cycles(input int n);
        bit c;
        repeat (n) step(c);
    endtask

    // mode 0: plain byte, 1: extra ioctl_wr while busy, 2: end download while busy
    task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input int mode);
        bit c;
        int pg, n, cyc, w0;
        bit early, early_done;
        logic [22:0] ea;
        pg = int'(a[24:14]);
        w0 = wr_count;
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        step(c);
        ioctl_wr = 1'b0;
        if (pg >= 3) begin
            m_drop++;
            chk("drop_wait", ioctl_wait, 0);
            cycles(8);
            chk("drop_nowr", wr_count - w0, 0);
            chk("drop_cnt", drop_cnt, m_drop);
            chk("drop_loaded", loaded, m_loaded);
            return;
        end
        ea = {pages[pg], a[13:0]};
        chk("wait_rise", ioctl_wait, 1);
        chk("latch_a", boot_a, ea);
        chk("latch_d", boot_dout, d);
        if (mode == 1) begin
            ioctl_addr = 25'($urandom);
            ioctl_dout = ~d;
            ioctl_wr   = 1'b1;
        end
        if (mode == 2) ioctl_download = 1'b0;
        n = 0; cyc = 0; early = 1'b0; early_done = 1'b0;
        while (n < 2 && cyc < 400) begin
            step(c);
            ioctl_wr = 1'b0;
            cyc++;
            if (c) n++;
            if (n < 2 && (!ioctl_wait || boot_a !== ea || boot_dout !== d)) early = 1'b1;
            if (done) early_done = 1'b1;
        end
        chk("ce_count", n, 2);
        chk("wait_held", early, 0);
        chk("wait_drop", ioctl_wait, 0);
        chk("wr_pulses", wr_count - w0, 1);
        chk("wr_addr", last_a, ea);
        chk("wr_data", last_d, d);
        m_loaded[pg] = 1'b1;
        chk("loaded", loaded, m_loaded);
        if (mode == 2) chk("done_early", early_done, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit c;
        int w0, cyc;
        logic [24:0] a;

        reset = 1'b1;
        cycles(3);
        chk("rst_wait", ioctl_wait, 0);
        chk("rst_wr", boot_wr, 0);
        chk("rst_a", boot_a, 0);
        chk("rst_dout", boot_dout, 0);
        chk("rst_loaded", loaded, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_proto", proto_err, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;

        ioctl_index = 8'd0;
        ioctl_download = 1'b1;
        #1 chk("active_on", active, 1);
        cycles(1);

        send_byte(25'h4005, 8'hA5, 0);
        chk("loaded_010", loaded, 3'b010);
        send_byte(25'h8000, 8'($urandom), 0);
        send_byte(25'hC000, 8'($urandom), 0);

        repeat (24) begin
            if ($urandom_range(0, 3) == 0) a = 25'($urandom);
            else                           a = 25'($urandom_range(0, 3 * 16384 - 1));
            send_byte(a, 8'($urandom), 0);
        end

        chk("proto_clear", proto_err, 0);
        send_byte(25'($urandom_range(0, 3 * 16384 - 1)), 8'($urandom), 1);
        chk("proto_set", proto_err, 1);

        mem_a = 23'h41C123;
        #1 chk("mask_41c123", rom_mask, 8'h00);
        mem_a = 23'h104000;
        #1 chk("mask_104000", rom_mask, 8'hFF);
        repeat (10) begin
            if ($urandom_range(0, 1) == 1) mem_a = {pages[$urandom_range(0, 2)], 14'($urandom)};
            else                           mem_a = 23'($urandom);
            #1 chk("mask_rand", rom_mask, m_mask(mem_a));
        end
        cycles(1);

        // download end while idle
        ioctl_download = 1'b0;
        #1 chk("active_off", active, 0);
        cycles(1);
        chk("done_pulse", done, 1);
        cycles(1);
        chk("done_one", done, 0);

        // other index: loader stays out of the way
        ioctl_index = 8'd1;
        ioctl_download = 1'b1;
        #1 chk("active_idx1", active, 0);
        w0 = wr_count;
        ioctl_addr = 25'h4000;
        ioctl_wr = 1'b1;
        step(c);
        ioctl_wr = 1'b0;
        chk("idx1_wait", ioctl_wait, 0);
        cycles(10);
        chk("idx1_nowr", wr_count - w0, 0);
        chk("idx1_loaded", loaded, m_loaded);
        chk("idx1_drop", drop_cnt, m_drop);
        ioctl_download = 1'b0;
        cycles(2);

        // new download clears status
        ioctl_index = 8'd0;
        ioctl_download = 1'b1;
        cycles(1);
        m_loaded = '0;
        m_drop = 0;
        chk("rise_loaded", loaded, 0);
        chk("rise_drop", drop_cnt, 0);
        chk("rise_proto", proto_err, 0);

        // download ends while a write is in flight
        send_byte(25'h0123, 8'h5A, 2);
        chk("done_at_idle", done, 0);
        cycles(1);
        chk("done_after", done, 1);
        cycles(1);
        chk("done_clear", done, 0);

        // reset in WRITE
        ioctl_download = 1'b1;
        cycles(1);
        m_loaded = '0;
        m_drop = 0;
        ioctl_addr = 25'h8010;
        ioctl_dout = 8'hC3;
        ioctl_wr = 1'b1;
        step(c);
        ioctl_wr = 1'b0;
        cyc = 0;
        while (!boot_wr && cyc < 400) begin
            step(c);
            cyc++;
        end
        chk("reach_write", boot_wr, 1);
        reset = 1'b1;
        step(c);
        chk("rstw_wr", boot_wr, 0);
        chk("rstw_wait", ioctl_wait, 0);
        chk("rstw_loaded", loaded, 0);
        step(c);
        reset = 1'b0;
        cycles(2);
        send_byte(25'h4321, 8'h3C, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
